pwm_pattern_seq: RTL and testbench

Upstream sequencer for the pattern PWM generator. Buffers a queue of pattern descriptors (pattern word, duty count, repeat count) written by the control side. Plays each descriptor into the PWM generator, issuing one single-cycle enable per playback and waiting for the generator's end-of-pattern flag before issuing the next. Holds the pattern and duty inputs stable for the whole playback and inserts a programmable gap between patterns.

---
 rtl/pwm_seq_pkg.sv | 28 ++
 rtl/pwm_seq_fifo.sv | 68 ++++++
 rtl/pwm_pattern_seq.sv | 207 ++++++++++++++++++++
 tb/tb_pwm_pattern_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types for the PWM pattern sequencer: FSM state encoding and the
// descriptor layout ({pattern, duty, repeat}) stored in the descriptor FIFO.
package pwm_seq_pkg;

    localparam int DUTY_W      = 8;
    localparam int REP_W       = 8;
    localparam int DESC_META_W = DUTY_W + REP_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_DONE,
        GAP,
        DRAIN
    } seq_state_e;

    // Low bits of a descriptor; the pattern word sits above this record.
    typedef struct packed {
        logic [DUTY_W-1:0] duty;
        logic [REP_W-1:0]  rep;
    } desc_meta_t;

    function automatic int desc_width(input int pat_w);
        return pat_w + DESC_META_W;
    endfunction

endpackage

// File: rtl/pwm_seq_fifo.sv
// Descriptor FIFO for the pattern sequencer: push/pop/flush, level and
// full/empty flags. The head entry is visible combinationally on dout.
module pwm_seq_fifo #(
    parameter int DW    = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_pop  = pop && !empty && !flush;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop) && !flush;
    assign level   = level_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Fall-through head so the sequencer can latch an entry in a single LOAD cycle.
    assign dout = mem[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/pwm_pattern_seq.sv
// Sequencer that plays queued pattern descriptors into the PWM generator.
// Optional watchdog on the end-of-pattern wait is enabled by SEQ_TIMEOUT_EN.
module pwm_pattern_seq
    import pwm_seq_pkg::*;
#(
    parameter int PAT_W      = 8,
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [PAT_W-1:0]         wr_pat,
    input  logic [7:0]               wr_duty,
    input  logic [7:0]               wr_rep,
    output logic                     wr_full,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     pwm_busy,
    input  logic                     pwm_valid,
    output logic                     pwm_en,
    output logic [PAT_W-1:0]         pwm_pat,
    output logic [7:0]               pwm_duty,
    output logic                     seq_busy,
    output logic                     seq_done,
    output logic                     timeout_err
);

    localparam int DESC_W = desc_width(PAT_W);

    seq_state_e        state_reg, state_next;
    logic [DESC_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty, fifo_pop, fifo_flush;
    desc_meta_t        head_meta;
    logic [PAT_W-1:0]  pat_reg;
    logic [7:0]        duty_reg, rep_reg, rep_cnt_reg, gap_cnt_reg;
    logic              gap_to_load_reg, gap_to_load_next;
    logic [1:0]        en_hist_reg;
    logic              done_reg, done_next, overflow_reg;
    logic              rep_inc, gap_start, wd_fire, drain_need, en_now;

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt_reg;
    logic            timeout_reg;
`endif

    pwm_seq_fifo #(.DW(DESC_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   ({wr_pat, wr_duty, wr_rep}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign head_meta  = fifo_dout[DESC_META_W-1:0];
    assign en_now     = (state_reg == ISSUE) && !abort;
    // An enable issued in the last two cycles may not have raised busy yet.
    assign drain_need = pwm_busy || (en_hist_reg != 2'b00);
    assign fifo_flush = abort || wd_fire;

    always_comb begin
        state_next       = state_reg;
        fifo_pop         = 1'b0;
        rep_inc          = 1'b0;
        gap_start        = 1'b0;
        gap_to_load_next = gap_to_load_reg;
        done_next        = 1'b0;
        wd_fire          = 1'b0;
        if (abort) begin
            state_next = drain_need ? DRAIN : IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !fifo_empty) state_next = LOAD;
                end
                LOAD: begin
                    fifo_pop   = 1'b1;
                    state_next = ISSUE;
                end
                ISSUE: state_next = WAIT_DONE;
                WAIT_DONE: begin
                    if (pwm_valid) begin
                        if (rep_cnt_reg < rep_reg) begin
                            rep_inc = 1'b1;
                            if (GAP_CYCLES == 0) begin
                                state_next = ISSUE;
                            end else begin
                                state_next       = GAP;
                                gap_start        = 1'b1;
                                gap_to_load_next = 1'b0;
                            end
                        end else if (!fifo_empty) begin
                            if (GAP_CYCLES == 0) begin
                                state_next = LOAD;
                            end else begin
                                state_next       = GAP;
                                gap_start        = 1'b1;
                                gap_to_load_next = 1'b1;
                            end
                        end else begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
                        wd_fire    = 1'b1;
                        state_next = IDLE;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt_reg == 8'(GAP_CYCLES - 1)) begin
                        state_next = gap_to_load_reg ? LOAD : ISSUE;
                    end
                end
                DRAIN: begin
                    if (!drain_need) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_reg         <= '0;
            duty_reg        <= '0;
            rep_reg         <= '0;
            rep_cnt_reg     <= '0;
            gap_cnt_reg     <= '0;
            gap_to_load_reg <= 1'b0;
            en_hist_reg     <= 2'b00;
            done_reg        <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            en_hist_reg     <= {en_hist_reg[0], en_now};
            done_reg        <= done_next;
            gap_to_load_reg <= gap_to_load_next;
            if (fifo_pop) begin
                pat_reg     <= fifo_dout[DESC_W-1 -: PAT_W];
                duty_reg    <= head_meta.duty;
                rep_reg     <= head_meta.rep;
                rep_cnt_reg <= '0;
            end else if (rep_inc) begin
                rep_cnt_reg <= rep_cnt_reg + 1'b1;
            end
            if (gap_start) begin
                gap_cnt_reg <= '0;
            end else if (state_reg == GAP) begin
                gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
            if (abort) begin
                overflow_reg <= 1'b0;
            end else if (wr_en && fifo_full && !fifo_pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wd_cnt_reg <= (state_reg == WAIT_DONE) ? wd_cnt_reg + 1'b1 : '0;
            if (wd_fire) begin
                timeout_reg <= 1'b1;
            end else if (start) begin
                timeout_reg <= 1'b0;
            end
        end
    end
    assign timeout_err = timeout_reg;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_err    = 1'b0;
`endif

    assign pwm_en   = en_now;
    assign pwm_pat  = pat_reg;
    assign pwm_duty = duty_reg;
    assign seq_busy = (state_reg != IDLE);
    assign seq_done = done_reg;
    assign wr_full  = fifo_full;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_pwm_pattern_seq.sv
// Scoreboard bench for pwm_pattern_seq: expected pwm_en / seq_done events are
// queued at stimulus time and checked by a monitor against a generator model.
module tb_pwm_pattern_seq;

    localparam int PAT_W = 8;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int TMO   = 100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [PAT_W-1:0] wr_pat = '0;
    logic [7:0]       wr_duty = '0;
    logic [7:0]       wr_rep = '0;
    logic             wr_full;
    logic [3:0]       fifo_level;
    logic             overflow;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             pwm_busy;
    logic             pwm_valid;
    logic             pwm_en;
    logic [PAT_W-1:0] pwm_pat;
    logic [7:0]       pwm_duty;
    logic             seq_busy;
    logic             seq_done;
    logic             timeout_err;

    typedef struct {
        bit         is_done;
        int         cyc;
        logic [7:0] pat;
        logic [7:0] duty;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // generator model state
    bit         gen_active = 0;
    bit         gen_mute = 0;
    int         gen_en_cyc = 0;
    logic [7:0] gen_pat = '0;
    logic [7:0] gen_duty = '0;

    pwm_pattern_seq #(
        .PAT_W(PAT_W), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_pat(wr_pat), .wr_duty(wr_duty), .wr_rep(wr_rep),
        .wr_full(wr_full), .fifo_level(fifo_level), .overflow(overflow),
        .start(start), .abort(abort),
        .pwm_busy(pwm_busy), .pwm_valid(pwm_valid),
        .pwm_en(pwm_en), .pwm_pat(pwm_pat), .pwm_duty(pwm_duty),
        .seq_busy(seq_busy), .seq_done(seq_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_desc(input logic [7:0] p, input logic [7:0] d, input logic [7:0] r);
        wr_en = 1'b1; wr_pat = p; wr_duty = d; wr_rep = r;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic exp_en(input int c, input logic [7:0] p, input logic [7:0] d);
        exp_t e;
        e.is_done = 1'b0; e.cyc = c; e.pat = p; e.duty = d;
        sb.push_back(e);
    endtask

    task automatic exp_done(input int c);
        exp_t e;
        e.is_done = 1'b1; e.cyc = c; e.pat = '0; e.duty = '0;
        sb.push_back(e);
    endtask

    task automatic check_drained(input string name);
        chk({name, "_events_left"}, sb.size(), 0);
        sb.delete();
    endtask

    // Generator: busy from en+2 through en+duty+3, valid pulse on the last busy cycle.
    initial begin
        pwm_busy = 1'b0;
        pwm_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (pwm_en && !gen_mute && !rst) begin
                gen_active = 1; gen_en_cyc = cyc; gen_pat = pwm_pat; gen_duty = pwm_duty;
            end
            @(posedge clk);
            #1;
            pwm_busy  = gen_active && (cyc >= gen_en_cyc + 2);
            pwm_valid = gen_active && (cyc == gen_en_cyc + 3 + int'(gen_duty));
            if (pwm_valid) gen_active = 0;
        end
    end

    // Monitor: each pwm_en / seq_done must match the head of the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (gen_active)
                chk("pat_stable", {16'h0, pwm_pat, pwm_duty}, {16'h0, gen_pat, gen_duty});
            if (pwm_en || seq_done) begin
                $display("event cyc=%0d en=%0b done=%0b pat=%02h duty=%0d",
                         cyc, pwm_en, seq_done, pwm_pat, pwm_duty);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got en=%0b done=%0b at cycle %0d, required none",
                             pwm_en, seq_done, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("evt_is_done", 32'(seq_done), 32'(e.is_done));
                    chk("evt_cycle", cyc, e.cyc);
                    if (!e.is_done) begin
                        chk("evt_pat", 32'(pwm_pat), 32'(e.pat));
                        chk("evt_duty", 32'(pwm_duty), 32'(e.duty));
                    end
                end
            end
        end
    end

    initial begin
        int s;
        // reset state
        repeat (3) tick();
        chk("rst_pwm_en", 32'(pwm_en), 0);
        chk("rst_pat_duty", {16'h0, pwm_pat, pwm_duty}, 0);
        chk("rst_seq_busy", 32'(seq_busy), 0);
        chk("rst_seq_done", 32'(seq_done), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_full_ovf", {30'h0, wr_full, overflow}, 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        rst = 1'b0;
        tick();

        // start with an empty queue is ignored
        start = 1'b1; tick(); start = 1'b0;
        chk("empty_start_busy", 32'(seq_busy), 0);
        repeat (4) tick();
        check_drained("empty_start");

        // single entry, played once
        push_desc(8'hA5, 8'd3, 8'd0);
        s = cyc;
        exp_en(s + 2, 8'hA5, 8'd3);
        exp_done(s + 9);
        start = 1'b1; tick(); start = 1'b0;
        goto(s + 8);
        chk("single_busy_mid", 32'(seq_busy), 1);
        goto(s + 10);
        chk("single_busy_after", 32'(seq_busy), 0);
        goto(s + 14);
        check_drained("single");

        // rep=2 with a 4-cycle gap: enables 5 cycles after each valid
        push_desc(8'h5A, 8'd3, 8'd2);
        s = cyc;
        exp_en(s + 2, 8'h5A, 8'd3);
        exp_en(s + 13, 8'h5A, 8'd3);
        exp_en(s + 24, 8'h5A, 8'd3);
        exp_done(s + 31);
        start = 1'b1; tick(); start = 1'b0;
        goto(s + 36);
        chk("repeat_busy_after", 32'(seq_busy), 0);
        check_drained("repeat");

        // three entries in order, next-entry spacing GAP+2
        push_desc(8'h01, 8'd1, 8'd0);
        push_desc(8'hF0, 8'd3, 8'd0);
        push_desc(8'h3C, 8'd0, 8'd0);
        s = cyc;
        exp_en(s + 2, 8'h01, 8'd1);
        exp_en(s + 12, 8'hF0, 8'd3);
        exp_en(s + 24, 8'h3C, 8'd0);
        exp_done(s + 28);
        start = 1'b1; tick(); start = 1'b0;
        goto(s + 33);
        check_drained("three");

        // fill, overflow, write during LOAD pop, then abort while busy
        for (int i = 0; i < DEPTH; i++) push_desc(8'(8'h10 + i), 8'd3, 8'd0);
        push_desc(8'hFF, 8'd3, 8'd0);
        chk("fill_full", 32'(wr_full), 1);
        chk("fill_overflow", 32'(overflow), 1);
        chk("fill_level", 32'(fifo_level), DEPTH);
        s = cyc;
        exp_en(s + 2, 8'h10, 8'd3);
        start = 1'b1; tick(); start = 1'b0;
        push_desc(8'hEE, 8'd3, 8'd0);
        chk("load_push_level", 32'(fifo_level), DEPTH);
        goto(s + 5);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_level", 32'(fifo_level), 0);
        chk("abort_overflow", 32'(overflow), 0);
        chk("abort_drain_busy", 32'(seq_busy), 1);
        goto(s + 9);
        chk("drain_busy_last", 32'(seq_busy), 1);
        goto(s + 10);
        chk("drain_idle", 32'(seq_busy), 0);
        goto(s + 16);
        check_drained("abort");

        // abort and start together: abort wins
        push_desc(8'h42, 8'd1, 8'd0);
        chk("abst_level_before", 32'(fifo_level), 1);
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        chk("abst_level", 32'(fifo_level), 0);
        chk("abst_busy", 32'(seq_busy), 0);
        repeat (6) tick();
        check_drained("abort_start");

`ifdef SEQ_TIMEOUT_EN
        // watchdog: generator silent, fires on the 100th WAIT_DONE cycle
        gen_mute = 1;
        push_desc(8'h77, 8'd1, 8'd0);
        push_desc(8'h88, 8'd1, 8'd0);
        s = cyc;
        exp_en(s + 2, 8'h77, 8'd1);
        start = 1'b1; tick(); start = 1'b0;
        goto(s + 102);
        chk("wd_before", 32'(timeout_err), 0);
        chk("wd_busy_before", 32'(seq_busy), 1);
        goto(s + 103);
        chk("wd_err", 32'(timeout_err), 1);
        chk("wd_level", 32'(fifo_level), 0);
        chk("wd_idle", 32'(seq_busy), 0);
        goto(s + 108);
        check_drained("watchdog");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
